// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: fixed-latency word memory serving cache refills and write-through stores
// Define MAIN_MEM_BOUNDS_CHECK_EN to flag word indices >= DEPTH instead of wrapping them.
module main_memory_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  mem_error
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IW-1:0] idx, idx_in;
  logic [DATA_WIDTH-1:0] wdata;
  logic [CW-1:0] cnt;
  logic op_wr, err, oob;
  assign word_idx = mem_addr[ADDR_WIDTH-1:2];
  assign idx_in = IW'(int'(word_idx) % DEPTH);
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  assign oob = int'(word_idx) >= DEPTH;
`else
  assign oob = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      wdata <= '0;
      op_wr <= 1'b0;
      err <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      mem_busy <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      case (state)
        IDLE: if (mem_read || mem_write) begin
          op_wr <= !mem_read;
          idx <= idx_in;
          wdata <= mem_wdata;
          err <= oob;
          cnt <= CW'(LATENCY - 1);
          mem_busy <= 1'b1;
          state <= LATENCY == 1 ? RESP : WAIT;
          mem_ready <= LATENCY == 1;
          mem_error <= LATENCY == 1 && oob;
          if (LATENCY == 1 && mem_read) mem_rdata <= oob ? '0 : mem[idx_in];
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= RESP;
            mem_ready <= 1'b1;
            mem_error <= err;
            if (!op_wr) mem_rdata <= err ? '0 : mem[idx];
          end
        end
        default: begin
          state <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end
  // Writes land at the edge that ends RESP, so a reset during the request discards them.
  always_ff @(posedge clock)
    if (!reset && state == RESP && op_wr && !err) mem[idx] <= wdata;
endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl: scoreboarded random/directed bench for main_memory_ctrl (LATENCY 4 and 1).
module tb_main_memory_ctrl;
  localparam int LAT = 4;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  typedef struct {int cyc; logic [31:0] data; bit err;} exp_t;
  logic clock = 1'b0, reset = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0, mem_ready, mem_busy, mem_error;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0, mem_rdata;
  logic r1 = 1'b0, w1 = 1'b0, rdy1, busy1, err1;
  logic [15:0] a1 = '0;
  logic [31:0] d1 = '0, rd1;
  main_memory_ctrl #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_error(mem_error)
  );
  main_memory_ctrl #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .mem_read(r1), .mem_write(w1),
    .mem_addr(a1), .mem_wdata(d1), .mem_rdata(rd1),
    .mem_ready(rdy1), .mem_busy(busy1), .mem_error(err1)
  );
  always #5 clock = ~clock;
  exp_t sb[$];
  exp_t e;
  logic [31:0] ref_mem [int];
  logic [31:0] last = '0, held = '0;
  int cyc = 0, busy_lo = 0, busy_hi = -1, vectors = 0, miscompares = 0;
  bit en = 1'b0;
  int op, w;
  logic [15:0] addr;
  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endfunction
  // Monitor: pops the scoreboard on every response and checks idle-time outputs.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (en) begin
      if (mem_ready) begin
        if (sb.size() == 0) chk("unexpected_ready", 32'(mem_ready), 32'd0);
        else begin
          e = sb.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("rdata", mem_rdata, e.data);
          chk("error", 32'(mem_error), 32'(e.err));
          held = e.data;
        end
      end else begin
        chk("rdata_hold", mem_rdata, held);
        chk("error_idle", 32'(mem_error), 32'd0);
      end
      chk("busy", 32'(mem_busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end
  // Called at a negedge; leaves at the negedge after the response with the request dropped.
  task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] d);
    int wi = int'(a[15:2]);
    bit oob = BOUNDS && wi >= 1024;
    int n = 0;
    wi = wi % 1024;
    mem_read = rd;
    mem_write = wr;
    mem_addr = a;
    mem_wdata = d;
    if (rd) last = oob ? 32'h0 : ref_mem[wi];
    else if (!oob) ref_mem[wi] = d;
    sb.push_back('{cyc + LAT, last, oob});
    busy_lo = cyc + 1;
    busy_hi = cyc + LAT;
    do begin
      @(negedge clock);
      n++;
    end while (!mem_ready && n < 3 * LAT);
    chk("ready_seen", 32'(mem_ready), 32'd1);
    if (!mem_ready) sb.delete();
    @(negedge clock);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask
  task automatic reset_mid();
    int a0 = cyc + 1;
    mem_read = 1'b1;
    mem_addr = 16'h0010;
    busy_lo = a0;
    busy_hi = a0 + LAT - 1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    mem_read = 1'b0;
    sb.delete();
    busy_hi = a0 + 1;
    last = '0;
    held = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    en = 1'b1;
    repeat (5) @(negedge clock);
    req(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
    req(1'b1, 1'b0, 16'h0010, 32'h0);
    req(1'b1, 1'b1, 16'h0010, 32'h12345678);
    req(1'b1, 1'b0, 16'h0013, 32'h0);
    reset_mid();
    req(1'b1, 1'b0, 16'h0010, 32'h0);
    for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 16'(i * 4), $urandom);
    req(1'b1, 1'b0, 16'h1000, 32'h0);
    req(1'b0, 1'b1, 16'h1004, 32'hCAFEF00D);
    req(1'b1, 1'b0, 16'h0004, 32'h0);
    repeat (150) begin
      op = int'($urandom_range(3));
      w = int'($urandom_range(7));
      addr = 16'((int'($urandom_range(1)) * 1024 + w) * 4 + int'($urandom_range(3)));
      repeat ($urandom_range(2)) @(negedge clock);
      req(op != 2, op >= 2, addr, $urandom);
    end
    w1 = 1'b1;
    a1 = 16'h0020;
    d1 = 32'hA5A50001;
    @(negedge clock);
    chk("l1_ready", 32'(rdy1), 32'd1);
    chk("l1_busy", 32'(busy1), 32'd1);
    @(negedge clock);
    chk("l1_ready_once", 32'(rdy1), 32'd0);
    chk("l1_idle", 32'(busy1), 32'd0);
    w1 = 1'b0;
    @(negedge clock);
    chk("l1_no_reaccept", 32'(busy1), 32'd0);
    r1 = 1'b1;
    @(negedge clock);
    chk("l1_read_ready", 32'(rdy1), 32'd1);
    chk("l1_rdata", rd1, 32'hA5A50001);
    chk("l1_error", 32'(err1), 32'd0);
    @(negedge clock);
    chk("l1_read_once", 32'(rdy1), 32'd0);
    r1 = 1'b0;
    @(negedge clock);
    chk("l1_read_idle", 32'(busy1), 32'd0);
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
